// File: rtl/mem_stage.sv
// MEM pipeline stage: zero-latency pass-through for ALU ops, IDLE/REQ/DONE data-cache FSM for loads/stores.
// Define MEM_ALIGN_CHECK_EN to add the mem_align_err output and trap misaligned half/word accesses.
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         MEM_valid,
  input  logic [154:0] EXE_MEM_bus_r,
  input  logic         WB_allow_in,
  input  logic         cancel,
  output logic         MEM_over,
  output logic         MEM_allow_in,
  output logic         WB_valid,
  output logic [117:0] MEM_WB_bus_r,
  output logic         dc_req,
  output logic [31:0]  dc_addr,
  output logic [3:0]   dc_wen,
  output logic [31:0]  dc_wdata,
  input  logic [31:0]  dc_rdata,
  input  logic         dc_ack
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic         mem_align_err
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  logic        instLoad, instStore, loadSign;
  logic [1:0]  lsSize;
  logic [31:0] storeData, exeResult, loResult, pc;
  logic        hiWrite, loWrite, wen, mfhi, mflo, mtc0, mfc0, syscall, eret;
  logic [4:0]  wdest;
  logic [7:0]  cp0rAddr;

  assign {instLoad, instStore, lsSize, loadSign, storeData, exeResult, loResult,
          hiWrite, loWrite, wen, wdest, mfhi, mflo, mtc0, mfc0, cp0rAddr,
          syscall, eret, pc} = EXE_MEM_bus_r;

  logic        isMem;
  logic        misalign;
  logic [31:0] effAddr;
  logic [3:0]  wenCalc;
  logic [31:0] wdataCalc;

  assign isMem = instLoad | instStore;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ((lsSize == 2'b01) && exeResult[0]) ||
                    (lsSize[1] && (exeResult[1:0] != 2'b00));
  assign effAddr  = exeResult;
`else
  // Without checking, half/word accesses silently drop the offending low address bits.
  assign misalign = 1'b0;
  always_comb begin
    effAddr = exeResult;
    if (lsSize[1])
      effAddr[1:0] = 2'b00;
    else if (lsSize == 2'b01)
      effAddr[0] = 1'b0;
  end
`endif

  always_comb begin
    wenCalc   = 4'b0000;
    wdataCalc = storeData;
    case (lsSize)
      2'b00: begin
        wenCalc   = 4'b0001 << effAddr[1:0];
        wdataCalc = {4{storeData[7:0]}};
      end
      2'b01: begin
        wenCalc   = 4'b0011 << effAddr[1:0];
        wdataCalc = {2{storeData[15:0]}};
      end
      default: begin
        wenCalc   = 4'b1111;
        wdataCalc = storeData;
      end
    endcase
    if (!instStore)
      wenCalc = 4'b0000;
  end

  state_t      state_q;
  logic        dcReq_q, cancelled_q, sign_q;
  logic [31:0] reqAddr_q, reqWdata_q, load_q;
  logic [3:0]  reqWen_q;
  logic [1:0]  lsb_q, size_q;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadExt;

  always_comb begin
    laneByte = dc_rdata[{lsb_q, 3'b000} +: 8];
    laneHalf = dc_rdata[{lsb_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   loadExt = {{24{sign_q & laneByte[7]}}, laneByte};
      2'b01:   loadExt = {{16{sign_q & laneHalf[15]}}, laneHalf};
      default: loadExt = dc_rdata;
    endcase
  end

  assign MEM_over     = MEM_valid && (isMem ? (state_q == DONE) : 1'b1);
  assign MEM_allow_in = !MEM_valid || (MEM_over && WB_allow_in);

  // Request fields are captured on entry to REQ so a flush upstream cannot disturb an in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dcReq_q     <= 1'b0;
      reqAddr_q   <= '0;
      reqWen_q    <= '0;
      reqWdata_q  <= '0;
      lsb_q       <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      cancelled_q <= 1'b0;
      load_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MEM_valid && isMem && !cancel) begin
            if (misalign) begin
              state_q <= DONE;
              load_q  <= '0;
            end else begin
              state_q     <= REQ;
              dcReq_q     <= 1'b1;
              reqAddr_q   <= effAddr;
              reqWen_q    <= wenCalc;
              reqWdata_q  <= wdataCalc;
              lsb_q       <= effAddr[1:0];
              size_q      <= lsSize;
              sign_q      <= loadSign;
              cancelled_q <= 1'b0;
            end
          end
        end
        REQ: begin
          if (cancel)
            cancelled_q <= 1'b1;
          if (dc_ack) begin
            dcReq_q  <= 1'b0;
            reqWen_q <= 4'b0000;
            if (cancel || cancelled_q) begin
              state_q <= IDLE;
            end else begin
              state_q <= DONE;
              load_q  <= loadExt;
            end
          end
        end
        DONE: begin
          if (cancel || (MEM_over && WB_allow_in))
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dc_req   = dcReq_q;
  assign dc_addr  = reqAddr_q;
  assign dc_wen   = reqWen_q;
  assign dc_wdata = reqWdata_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign mem_align_err = (state_q == DONE) && misalign;
`endif

  logic [31:0]  memResult;
  logic [117:0] wbBus_d;

  assign memResult = instLoad ? load_q : exeResult;
  assign wbBus_d   = {wen, wdest, memResult, loResult, hiWrite, loWrite,
                      mfhi, mflo, mtc0, mfc0, cp0rAddr, syscall, eret, pc};

  // A flush always kills the WB slot, even while WB is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WB_valid     <= 1'b0;
      MEM_WB_bus_r <= '0;
    end else if (WB_allow_in) begin
      WB_valid <= MEM_over && !cancel;
      if (MEM_over)
        MEM_WB_bus_r <= wbBus_d;
    end else if (cancel) begin
      WB_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected WB buses, a monitor pops them on each WB transfer.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         MEM_valid;
  logic [154:0] EXE_MEM_bus_r;
  logic         WB_allow_in;
  logic         cancel;
  logic         MEM_over;
  logic         MEM_allow_in;
  logic         WB_valid;
  logic [117:0] MEM_WB_bus_r;
  logic         dc_req;
  logic [31:0]  dc_addr;
  logic [3:0]   dc_wen;
  logic [31:0]  dc_wdata;
  logic [31:0]  dc_rdata;
  logic         dc_ack;
`ifdef MEM_ALIGN_CHECK_EN
  logic         mem_align_err;
`endif

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .MEM_valid    (MEM_valid),
    .EXE_MEM_bus_r(EXE_MEM_bus_r),
    .WB_allow_in  (WB_allow_in),
    .cancel       (cancel),
    .MEM_over     (MEM_over),
    .MEM_allow_in (MEM_allow_in),
    .WB_valid     (WB_valid),
    .MEM_WB_bus_r (MEM_WB_bus_r),
    .dc_req       (dc_req),
    .dc_addr      (dc_addr),
    .dc_wen       (dc_wen),
    .dc_wdata     (dc_wdata),
    .dc_rdata     (dc_rdata),
    .dc_ack       (dc_ack)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .mem_align_err(mem_align_err)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] LO = 32'h0C0F_FEE0;

  int total = 0;
  int bad = 0;
  logic [117:0] expQ[$];

  int          ackDelay = 0;
  logic [31:0] rdataVal = '0;
  int          reqCycles = 0;
  int          reqCount = 0;
  int          ackCount = 0;
  int          lastReqLen = 0;
  logic [31:0] capAddr = '0;
  logic [3:0]  capWen = '0;
  logic [31:0] capWdata = '0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [154:0] bus, input logic allow, input logic canc);
    @(posedge clk);
    #1;
    MEM_valid     = v;
    EXE_MEM_bus_r = bus;
    WB_allow_in   = allow;
    cancel        = canc;
  endtask

  function automatic logic [154:0] mkIn(input logic ld, input logic st, input logic [1:0] sz,
                                        input logic sg, input logic [31:0] sd, input logic [31:0] exe,
                                        input logic wen, input logic [4:0] wd, input logic [31:0] pc);
    mkIn = {ld, st, sz, sg, sd, exe, LO, 1'b0, 1'b1, wen, wd,
            1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, pc};
  endfunction

  function automatic logic [117:0] mkOut(input logic wen, input logic [4:0] wd,
                                         input logic [31:0] res, input logic [31:0] pc);
    mkOut = {wen, wd, res, LO, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, pc};
  endfunction

  // Cache model: acknowledges each request after ackDelay extra REQ cycles and checks request stability.
  initial begin
    dc_ack   = 1'b0;
    dc_rdata = '0;
    forever begin
      @(negedge clk);
      dc_ack = 1'b0;
      if (dc_req && !reset) begin
        if (reqCycles == 0) begin
          capAddr  = dc_addr;
          capWen   = dc_wen;
          capWdata = dc_wdata;
          reqCount++;
        end else begin
          checkOutput("req_addr_stable", dc_addr, capAddr);
          checkOutput("req_wen_stable", dc_wen, capWen);
          checkOutput("req_wdata_stable", dc_wdata, capWdata);
        end
        if (reqCycles == ackDelay) begin
          dc_ack     = 1'b1;
          dc_rdata   = rdataVal;
          lastReqLen = reqCycles + 1;
          reqCycles  = 0;
          ackCount++;
        end else begin
          reqCycles++;
        end
      end
    end
  end

  initial begin
    logic [117:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && WB_valid && WB_allow_in) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_wb actual=WB_valid=1 bus=%0h expected=no transfer at %0t",
                   MEM_WB_bus_r, $time);
        end else begin
          exp = expQ.pop_front();
          checkOutput("wb_bus", MEM_WB_bus_r, exp);
        end
      end
    end
  end

  task automatic runMem(input logic [154:0] bus, input int delay, input logic [31:0] rdata,
                        input logic [117:0] expWb);
    int cyc;
    bit seen;
    ackDelay = delay;
    rdataVal = rdata;
    applyStimulus(1'b1, bus, 1'b1, 1'b0);
    expQ.push_back(expWb);
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (MEM_over) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL mem_over_timeout actual=none expected=MEM_over within 30 cycles");
    end else begin
      checkOutput("mem_latency", cyc, 3 + delay);
      checkOutput("req_len", lastReqLen, delay + 1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [154:0] lwBus;
    logic [117:0] addExp;
    int n;
    bit hit;
    reset         = 1'b1;
    MEM_valid     = 1'b0;
    EXE_MEM_bus_r = '0;
    WB_allow_in   = 1'b1;
    cancel        = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_wb_valid", WB_valid, 1'b0);
    checkOutput("rst_wb_bus", MEM_WB_bus_r, '0);
    checkOutput("rst_dc_req", dc_req, 1'b0);
    checkOutput("rst_dc_wen", dc_wen, 4'b0000);
    checkOutput("rst_mem_over", MEM_over, 1'b0);
    checkOutput("rst_allow_in", MEM_allow_in, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;

    // ADD: completes in the cycle it is presented
    applyStimulus(1'b1, mkIn(0, 0, 2'b00, 0, 32'h0, 32'h0000_1234, 1, 5'd3, 32'h400), 1'b1, 1'b0);
    expQ.push_back(mkOut(1, 5'd3, 32'h0000_1234, 32'h400));
    @(negedge clk);
    checkOutput("add_mem_over", MEM_over, 1'b1);
    checkOutput("add_allow_in", MEM_allow_in, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    runMem(mkIn(1, 0, 2'b00, 1, 32'h0, 32'h0000_0103, 1, 5'd4, 32'h404), 3, 32'h80FF_0000,
           mkOut(1, 5'd4, 32'hFFFF_FF80, 32'h404));
    checkOutput("lb_wen", capWen, 4'b0000);

    runMem(mkIn(0, 1, 2'b01, 0, 32'h0000_ABCD, 32'h0000_0102, 0, 5'd0, 32'h408), 2, 32'h0,
           mkOut(0, 5'd0, 32'h0000_0102, 32'h408));
    checkOutput("sh_wen", capWen, 4'b1100);
    checkOutput("sh_wdata", capWdata, 32'hABCD_ABCD);
    checkOutput("sh_addr", capAddr, 32'h0000_0102);
    @(negedge clk);
    checkOutput("sh_wen_after", dc_wen, 4'b0000);
    checkOutput("sh_req_after", dc_req, 1'b0);

    runMem(mkIn(1, 0, 2'b01, 0, 32'h0, 32'h0000_0202, 1, 5'd5, 32'h40C), 0, 32'h8001_1234,
           mkOut(1, 5'd5, 32'h0000_8001, 32'h40C));
    runMem(mkIn(1, 0, 2'b01, 1, 32'h0, 32'h0000_0600, 1, 5'd6, 32'h410), 1, 32'h0000_F00F,
           mkOut(1, 5'd6, 32'hFFFF_F00F, 32'h410));
    runMem(mkIn(1, 0, 2'b00, 0, 32'h0, 32'h0000_0702, 1, 5'd7, 32'h414), 0, 32'h00AB_0000,
           mkOut(1, 5'd7, 32'h0000_00AB, 32'h414));
    runMem(mkIn(1, 0, 2'b10, 0, 32'h0, 32'h0000_0300, 1, 5'd8, 32'h418), 1, 32'hDEAD_BEEF,
           mkOut(1, 5'd8, 32'hDEAD_BEEF, 32'h418));
    runMem(mkIn(0, 1, 2'b00, 0, 32'h1234_565A, 32'h0000_0401, 0, 5'd0, 32'h41C), 0, 32'h0,
           mkOut(0, 5'd0, 32'h0000_0401, 32'h41C));
    checkOutput("sb_wen", capWen, 4'b0010);
    checkOutput("sb_wdata", capWdata, 32'h5A5A_5A5A);
    runMem(mkIn(0, 1, 2'b10, 0, 32'h1122_3344, 32'h0000_0500, 0, 5'd0, 32'h420), 0, 32'h0,
           mkOut(0, 5'd0, 32'h0000_0500, 32'h420));
    checkOutput("sw_wen", capWen, 4'b1111);
    checkOutput("sw_wdata", capWdata, 32'h1122_3344);

    // Cancel while the request is outstanding: nothing may reach WB
    ackDelay = 2;
    rdataVal = 32'hFFFF_FFFF;
    n = ackCount;
    lwBus = mkIn(1, 0, 2'b10, 0, 32'h0, 32'h0000_0800, 1, 5'd9, 32'h424);
    applyStimulus(1'b1, lwBus, 1'b1, 1'b0);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (dc_req) hit = 1;
    end
    checkOutput("cancel_req_seen", hit, 1'b1);
    applyStimulus(1'b1, lwBus, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && ackCount == n; i++) begin
      @(negedge clk);
      checkOutput("cancel_no_over", MEM_over, 1'b0);
    end
    checkOutput("cancel_acked", ackCount, n + 1);
    @(negedge clk);
    checkOutput("cancel_req_dropped", dc_req, 1'b0);
    checkOutput("cancel_wb_valid", WB_valid, 1'b0);
    checkOutput("cancel_allow_in", MEM_allow_in, 1'b1);
    runMem(mkIn(1, 0, 2'b00, 0, 32'h0, 32'h0000_0901, 1, 5'd10, 32'h428), 0, 32'h0000_C300,
           mkOut(1, 5'd10, 32'h0000_00C3, 32'h428));

    // WB stall: ADD sits in the WB register while a load waits in DONE
    addExp = mkOut(1, 5'd11, 32'h0000_5555, 32'h42C);
    applyStimulus(1'b1, mkIn(0, 0, 2'b00, 0, 32'h0, 32'h0000_5555, 1, 5'd11, 32'h42C), 1'b1, 1'b0);
    expQ.push_back(addExp);
    ackDelay = 0;
    rdataVal = 32'h0BAD_F00D;
    lwBus = mkIn(1, 0, 2'b10, 0, 32'h0, 32'h0000_0A00, 1, 5'd12, 32'h430);
    applyStimulus(1'b1, lwBus, 1'b0, 1'b0);
    expQ.push_back(mkOut(1, 5'd12, 32'h0BAD_F00D, 32'h430));
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (MEM_over) hit = 1;
    end
    checkOutput("hold_done_seen", hit, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("hold_mem_over", MEM_over, 1'b1);
      checkOutput("hold_allow_in", MEM_allow_in, 1'b0);
      checkOutput("hold_wb_valid", WB_valid, 1'b1);
      checkOutput("hold_wb_bus", MEM_WB_bus_r, addExp);
    end
    applyStimulus(1'b1, lwBus, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("release_allow_in", MEM_allow_in, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("release_idle", MEM_allow_in, 1'b1);

`ifdef MEM_ALIGN_CHECK_EN
    n = reqCount;
    applyStimulus(1'b1, mkIn(1, 0, 2'b10, 0, 32'h0, 32'h0000_0102, 1, 5'd13, 32'h434), 1'b1, 1'b0);
    expQ.push_back(mkOut(1, 5'd13, 32'h0000_0000, 32'h434));
    @(negedge clk);
    checkOutput("align_over_early", MEM_over, 1'b0);
    @(negedge clk);
    checkOutput("align_over", MEM_over, 1'b1);
    checkOutput("align_err", mem_align_err, 1'b1);
    checkOutput("align_no_req", dc_req, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("align_err_clear", mem_align_err, 1'b0);
    checkOutput("align_req_count", reqCount, n);
`else
    runMem(mkIn(0, 1, 2'b01, 0, 32'h0000_7777, 32'h0000_0203, 0, 5'd0, 32'h434), 0, 32'h0,
           mkOut(0, 5'd0, 32'h0000_0203, 32'h434));
    checkOutput("force_addr", capAddr, 32'h0000_0202);
    checkOutput("force_wen", capWen, 4'b1100);
    checkOutput("force_wdata", capWdata, 32'h7777_7777);
`endif

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- MEM_valid  in  1  instruction present in MEM
- EXE_MEM_bus_r  in  155  fields MSB→LSB:
  - inst_load, inst_store, ls_size[1:0] (00 byte, 01 half, 10 word), load_sign
  - store_data[31:0], exe_result[31:0], lo_result[31:0]
  - hi_write, lo_write, wen, wdest[4:0], mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, pc[31:0]
- WB_allow_in  in  1  WB can accept
- cancel  in  1  flush from WB
- MEM_over  out  1  MEM work complete this cycle
- MEM_allow_in  out  1  MEM can accept next instruction
- WB_valid  out  1  registered valid to WB
- MEM_WB_bus_r  out  118  registered, fields MSB→LSB:
  - wen, wdest, mem_result, lo_result, hi_write, lo_write
  - mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret, pc
- dc_req  out  1  data-cache request, held until dc_ack
- dc_addr  out  32  access address
- dc_wen  out  4  byte write enables; 0 = read
- dc_wdata  out  32  lane-aligned store data
- dc_rdata  in  32  read word, valid with dc_ack
- dc_ack  in  1  one-cycle completion pulse

Function
REQ-002 Non-memory instruction: MEM_over = MEM_valid, same cycle (zero latency); mem_result = exe_result.
REQ-003 Load/store FSM states: IDLE, REQ, DONE.
- IDLE→REQ when MEM_valid and (inst_load or inst_store) and not cancel.
- REQ→DONE on dc_ack.
- DONE→IDLE when MEM_over and WB_allow_in.
REQ-004 dc_req SHALL be 1 exactly in REQ; dc_addr, dc_wen, dc_wdata SHALL be stable while in REQ.
REQ-005 Memory MEM_over SHALL be 1 only in DONE; minimum latency 2 cycles from MEM_valid (ack on first REQ cycle).
REQ-006 Store lanes (addr[1:0]):
- byte: dc_wen = 0001 << addr[1:0]; data replicated ×4
- half: dc_wen = 0011 << addr[1:0]; data replicated ×2
- word: dc_wen = 1111
REQ-007 Load: at dc_ack, lane selected by addr[1:0]; sign-extend if load_sign, else zero-extend; result latched into a 32-bit register used as mem_result in DONE.
REQ-008 MEM_allow_in = !MEM_valid | (MEM_over & WB_allow_in).
REQ-009 Output register on clk when WB_allow_in:
- WB_valid ← MEM_over & !cancel
- MEM_WB_bus_r ← assembled bus when MEM_over
REQ-010 When WB_allow_in = 0: WB_valid, MEM_WB_bus_r and FSM (in DONE) SHALL hold.
REQ-011 cancel in IDLE or DONE: FSM → IDLE next edge; WB_valid ← 0.
REQ-012 cancel in REQ: request SHALL NOT be withdrawn; FSM waits for dc_ack, discards data, then goes to IDLE; MEM_over stays 0 throughout.
REQ-013 cancel and dc_ack in the same cycle: FSM → IDLE; data discarded.

Reset
REQ-014 On reset, asynchronously:
- FSM = IDLE
- WB_valid = 0
- MEM_WB_bus_r = 0
- load register = 0
- dc_req = 0, dc_wen = 0
REQ-015 Reset mid-REQ abandons the request; the cache is reset by the same reset.

Configuration
REQ-016 Macro MEM_ALIGN_CHECK_EN controls alignment checking.
- Defined: adds output mem_align_err (1 bit, reset 0).
  - Misaligned access (half with addr[0] = 1; word with addr[1:0] ≠ 00): no dc_req issued; FSM goes IDLE→DONE directly.
  - mem_align_err = 1 while in DONE; load result 0; no write.
- Undefined: no mem_align_err port; address low bits forced to 0 for half/word.

Verification
REQ-017 Directed scenarios (bench SHALL cover):
- ADD, exe_result = 0x1234, WB_allow_in = 1 → MEM_over same cycle; next edge WB_valid = 1, mem_result = 0x1234.
- LB addr 0x103, dc_rdata = 0x80FF_0000, ack 3 cycles after dc_req → mem_result = 0xFFFF_FF80; MEM_over only in DONE.
- SH addr 0x102, store_data = 0xABCD → dc_wen = 1100, dc_wdata = 0xABCD_ABCD, dc_req held until ack.
- cancel during REQ, ack 2 cycles later → no WB_valid; FSM IDLE after ack; next instruction accepted.
- WB_allow_in = 0 for 3 cycles in DONE → outputs stable, MEM_allow_in = 0; released on the following edge.
- MEM_ALIGN_CHECK_EN defined, LW addr 0x102 → dc_req never 1, mem_align_err = 1, mem_result = 0.
